// File: rtl/inst_encoder_loader_if.sv
// Field-set stream into the encoder and the instruction-memory write bus out of it.
interface inst_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [1:0]        fmt;
  logic [2:0]        opcode;
  logic [1:0]        fn;
  logic [2:0]        rd;
  logic [2:0]        ra;
  logic [2:0]        rb;
  logic [6:0]        immi;
  logic [7:0]        immj;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    output in_valid, in_last, fmt, opcode, fn, rd, ra, rb, immi, immj, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_last, fmt, opcode, fn, rd, ra, rb, immi, immj, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_encoder_loader.sv
// Packs decoded instruction fields into 16-bit words, buffers them in a FIFO and
// writes them to instruction memory at consecutive addresses from a loaded base.
module inst_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  inst_encoder_loader_if.slave bus,
  output logic                done,
  output logic                err,
  output logic [ADDR_W:0]     wr_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [15:0]       fifo [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] addr;
  logic              legal;
  logic [15:0]       word;
  logic              accept;
  logic              push;
  logic              pop;

  always_comb begin
    legal = 1'b0;
    word  = '0;
    unique case (bus.fmt)
      2'd0: begin
        legal = (bus.opcode == 3'd0);
        word  = {3'b000, bus.fn, 2'b00, bus.rd, bus.ra, bus.rb};
      end
      2'd1: begin
        legal = (bus.opcode != 3'd0);
        word  = {bus.opcode, bus.immi, bus.ra, bus.rb};
      end
      2'd2: begin
        legal = (bus.opcode != 3'd0);
        word  = {bus.opcode, 5'b00000, bus.immj};
      end
      default: begin
        legal = 1'b0;
        word  = '0;
      end
    endcase
  end

  // in_ready looks at the pre-pop count, so a full FIFO never accepts on a pop cycle
  assign bus.in_ready  = (state == RUN) && (count < CNT_FULL);
  assign bus.mem_we    = (count != '0);
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = fifo[rd_ptr];

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && legal;
  assign pop    = bus.mem_we && bus.mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      wr_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      done <= 1'b0;

      if (push) begin
        fifo[wr_ptr] <= word;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        addr     <= addr + ADDR_W'(1);
        wr_count <= wr_count + (ADDR_W+1)'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase

      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            addr     <= base_addr;
            wr_count <= '0;
            err      <= 1'b0;
          end
        end
        RUN: begin
          if (accept && !legal) err <= 1'b1;
          if (accept && bus.in_last) state <= DRAIN;
        end
        DRAIN: begin
          if (count == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: table of single-set sessions plus
// hand-written multi-word, backpressure, illegal, wrap and reset sequences.
module tb_inst_encoder_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic       done;
  logic       err;
  logic [8:0] wr_count;

  inst_encoder_loader_if #(.ADDR_W(8)) bus ();

  inst_encoder_loader #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .done      (done),
    .err       (err),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;
  wr_t writes[$];

  always @(posedge clk) begin
    if (!rst && bus.mem_we && bus.mem_ack)
      writes.push_back('{addr: bus.mem_addr, data: bus.mem_wdata});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic begin_session(input logic [7:0] base);
    writes.delete();
    base_addr = base;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send(input logic [1:0] f, input logic [2:0] op, input logic [1:0] fnv,
                      input logic [2:0] rdv, input logic [2:0] rav, input logic [2:0] rbv,
                      input logic [6:0] imi, input logic [7:0] imj, input logic last);
    bit accepted;
    accepted     = 1'b0;
    bus.fmt      = f;
    bus.opcode   = op;
    bus.fn       = fnv;
    bus.rd       = rdv;
    bus.ra       = rav;
    bus.rb       = rbv;
    bus.immi     = imi;
    bus.immj     = imj;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 100 && !accepted; t++) begin
      if (bus.in_ready) accepted = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!accepted) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    if (seen) begin
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    end
  endtask

  typedef struct {
    logic [1:0]  fmt;
    logic [2:0]  op;
    logic [1:0]  fn;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [6:0]  immi;
    logic [7:0]  immj;
    logic        legal;
    logic [15:0] word;
  } vec_t;
  vec_t vecs[11];

  initial begin
    vecs[0]  = '{2'd0, 3'd0, 2'd1, 3'd3, 3'd5, 3'd7, 7'h00, 8'h00, 1'b1, 16'h08EF};
    vecs[1]  = '{2'd1, 3'd2, 2'd0, 3'd0, 3'd1, 3'd2, 7'h15, 8'h00, 1'b1, 16'h454A};
    vecs[2]  = '{2'd2, 3'd7, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'hA5, 1'b1, 16'hE0A5};
    vecs[3]  = '{2'd0, 3'd0, 2'd3, 3'd7, 3'd7, 3'd7, 7'h00, 8'h00, 1'b1, 16'h19FF};
    vecs[4]  = '{2'd1, 3'd7, 2'd3, 3'd7, 3'd7, 3'd7, 7'h7F, 8'hFF, 1'b1, 16'hFFFF};
    vecs[5]  = '{2'd2, 3'd1, 2'd3, 3'd7, 3'd7, 3'd7, 7'h7F, 8'h00, 1'b1, 16'h2000};
    vecs[6]  = '{2'd0, 3'd0, 2'd2, 3'd0, 3'd0, 3'd0, 7'h7F, 8'hFF, 1'b1, 16'h1000};
    vecs[7]  = '{2'd0, 3'd3, 2'd1, 3'd1, 3'd1, 3'd1, 7'h00, 8'h00, 1'b0, 16'h0000};
    vecs[8]  = '{2'd1, 3'd0, 2'd0, 3'd0, 3'd1, 3'd2, 7'h15, 8'h00, 1'b0, 16'h0000};
    vecs[9]  = '{2'd2, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'hA5, 1'b0, 16'h0000};
    vecs[10] = '{2'd3, 3'd5, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'h00, 1'b0, 16'h0000};

    rst = 1'b1; start = 1'b0; base_addr = '0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.fmt = '0; bus.opcode = '0; bus.fn = '0;
    bus.rd = '0; bus.ra = '0; bus.rb = '0; bus.immi = '0; bus.immj = '0; bus.mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);

    // Table: one set per session, in_last=1, immediate ack
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 11; i++) begin
      logic [7:0] base;
      base = 8'h80 + 8'(i * 4);
      begin_session(base);
      send(vecs[i].fmt, vecs[i].op, vecs[i].fn, vecs[i].rd, vecs[i].ra, vecs[i].rb,
           vecs[i].immi, vecs[i].immj, 1'b1);
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_nwrites", i), 32'(writes.size()), 32'(vecs[i].legal));
      if (vecs[i].legal && writes.size() == 1) begin
        chk($sformatf("vec%0d_addr", i), 32'(writes[0].addr), 32'(base));
        chk($sformatf("vec%0d_word", i), 32'(writes[0].data), 32'(vecs[i].word));
      end
      chk($sformatf("vec%0d_wr_count", i), 32'(wr_count), 32'(vecs[i].legal));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(!vecs[i].legal));
    end

    // I then J in one session
    begin_session(8'h20);
    send(2'd1, 3'd2, 2'd0, 3'd0, 3'd1, 3'd2, 7'h15, 8'h00, 1'b0);
    send(2'd2, 3'd7, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'hA5, 1'b1);
    wait_done("ij");
    chk("ij_nwrites", 32'(writes.size()), 32'd2);
    if (writes.size() == 2) begin
      chk("ij_addr0", 32'(writes[0].addr), 32'h20);
      chk("ij_data0", 32'(writes[0].data), 32'h454A);
      chk("ij_addr1", 32'(writes[1].addr), 32'h21);
      chk("ij_data1", 32'(writes[1].data), 32'hE0A5);
    end
    chk("ij_wr_count", 32'(wr_count), 32'd2);

    // Backpressure: 4 accepted then in_ready drops, bus holds stable
    bus.mem_ack = 1'b0;
    begin_session(8'h40);
    send(2'd2, 3'd1, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'h00, 1'b0);
    chk("bp_latency_we", 32'(bus.mem_we), 32'd1);
    chk("bp_latency_wdata", 32'(bus.mem_wdata), 32'h2000);
    for (int i = 1; i < 4; i++)
      send(2'd2, 3'd1, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'(i), 1'b0);
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.fmt = 2'd2; bus.opcode = 3'd1; bus.immj = 8'h04; bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp_stall%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp_stall%0d_we", c), 32'(bus.mem_we), 32'd1);
      chk($sformatf("bp_stall%0d_addr", c), 32'(bus.mem_addr), 32'h40);
      chk($sformatf("bp_stall%0d_wdata", c), 32'(bus.mem_wdata), 32'h2000);
    end
    chk("bp_stall_nwrites", 32'(writes.size()), 32'd0);
    bus.mem_ack = 1'b1;
    send(2'd2, 3'd1, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'h04, 1'b0);
    send(2'd2, 3'd1, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'h05, 1'b1);
    wait_done("bp");
    chk("bp_nwrites", 32'(writes.size()), 32'd6);
    if (writes.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("bp_addr%0d", i), 32'(writes[i].addr), 32'h40 + 32'(i));
        chk($sformatf("bp_data%0d", i), 32'(writes[i].data), 32'h2000 + 32'(i));
      end
    end
    chk("bp_wr_count", 32'(wr_count), 32'd6);

    // Illegal sets mixed with one legal set
    begin_session(8'h50);
    send(2'd0, 3'd3, 2'd1, 3'd1, 3'd1, 3'd1, 7'h00, 8'h00, 1'b0);
    send(2'd1, 3'd2, 2'd0, 3'd0, 3'd1, 3'd2, 7'h15, 8'h00, 1'b0);
    send(2'd3, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'h00, 1'b1);
    wait_done("ill");
    chk("ill_nwrites", 32'(writes.size()), 32'd1);
    if (writes.size() == 1) begin
      chk("ill_addr", 32'(writes[0].addr), 32'h50);
      chk("ill_data", 32'(writes[0].data), 32'h454A);
    end
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_wr_count", 32'(wr_count), 32'd1);

    // Address wrap
    begin_session(8'hFF);
    send(2'd2, 3'd3, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'h11, 1'b0);
    send(2'd2, 3'd3, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'h22, 1'b1);
    wait_done("wrap");
    chk("wrap_nwrites", 32'(writes.size()), 32'd2);
    if (writes.size() == 2) begin
      chk("wrap_addr0", 32'(writes[0].addr), 32'hFF);
      chk("wrap_data0", 32'(writes[0].data), 32'h6011);
      chk("wrap_addr1", 32'(writes[1].addr), 32'h00);
      chk("wrap_data1", 32'(writes[1].data), 32'h6022);
    end
    chk("wrap_wr_count", 32'(wr_count), 32'd2);
    chk("wrap_final_addr", 32'(bus.mem_addr), 32'h01);

    // Asynchronous reset with words buffered
    bus.mem_ack = 1'b0;
    begin_session(8'h60);
    send(2'd3, 3'd0, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++)
      send(2'd2, 3'd5, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'(8'h90 + i), 1'b0);
    chk("pre_rst_err", 32'(err), 32'd1);
    chk("pre_rst_we", 32'(bus.mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_we", 32'(bus.mem_we), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_wr_count", 32'(wr_count), 32'd0);
    chk("arst_addr", 32'(bus.mem_addr), 32'h0);
    chk("arst_wdata", 32'(bus.mem_wdata), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b1;
    begin_session(8'h70);
    send(2'd2, 3'd1, 2'd0, 3'd0, 3'd0, 3'd0, 7'h00, 8'h33, 1'b1);
    wait_done("post_rst");
    chk("post_rst_nwrites", 32'(writes.size()), 32'd1);
    if (writes.size() == 1) begin
      chk("post_rst_addr", 32'(writes[0].addr), 32'h70);
      chk("post_rst_data", 32'(writes[0].data), 32'h2033);
    end
    chk("post_rst_wr_count", 32'(wr_count), 32'd1);
    chk("post_rst_err", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
